// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver with input synchronisers, an optional clock
//   glitch filter, odd-parity / framing checks, an inactivity timeout and a
//   show-ahead receive FIFO with a valid/ready handshake.
//
//   Optional feature macro: PS2_GLITCH_FILTER_EN
//     defined   -> PS/2 clock must hold a new level for FILTER_LEN samples
//     undefined -> filtered clock is the synchronised clock
//
// Ports
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_ps2_clk     raw PS/2 clock pin (asynchronous)
//   i_ps2_data    raw PS/2 data pin (asynchronous)
//   o_data        FIFO head byte (valid while o_data_valid)
//   o_data_valid  FIFO not empty
//   i_data_ready  consumer accepts head this cycle
//   o_parity_err  1-cycle pulse: bad parity, byte dropped
//   o_frame_err   1-cycle pulse: bad stop bit or mid-frame timeout
//   o_overflow    1-cycle pulse: good byte dropped, FIFO full
//   o_fifo_count  number of stored entries
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic [7:0]                    o_data,
  output logic                          o_data_valid,
  input  logic                          i_data_ready,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Elaboration-time parameter sanity check
  if (SYNC_STAGES < 2 || FILTER_LEN < 2 || TIMEOUT_CYCLES < 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("ps2_rx_fifo: illegal parameter value");
  end

  // ---------------------------------------------------------------------------
  // Input synchronisers (reset to idle-high so no false edge after reset)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Optional glitch filter on the PS/2 clock
  // ---------------------------------------------------------------------------
  logic clk_f;

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;

  // flt_cnt counts consecutive samples that disagree with the current level;
  // the level flips on the FILTER_LEN-th such sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_f   <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end
`else
  assign clk_f = clk_s;
`endif

  // ---------------------------------------------------------------------------
  // Falling-edge strobe, registered so pin-to-strobe is SYNC_STAGES+1 cycles
  // ---------------------------------------------------------------------------
  logic clk_q, strobe;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_q  <= 1'b1;
      strobe <= 1'b0;
    end else begin
      clk_q  <= clk_f;
      strobe <= clk_q & ~clk_f;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;
  state_t state, state_n;

  logic [7:0]    shreg;
  logic [2:0]    idx;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          push_req, par_err_c, frm_err_c;

  assign timeout = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Timeout wins over a strobe arriving in the same cycle.
  always_comb begin
    state_n = state;
    if (timeout) begin
      state_n = S_IDLE;
    end else if (strobe) begin
      case (state)
        S_IDLE:  if (!dat_s) state_n = S_DATA;
        S_DATA:  if (idx == 3'd7) state_n = S_PAR;
        S_PAR:   state_n = S_STOP;
        S_STOP:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push_req  = 1'b0;
    par_err_c = 1'b0;
    frm_err_c = timeout;
    if (!timeout && strobe && state == S_STOP) begin
      if (!dat_s)                 frm_err_c = 1'b1;
      else if (^{shreg, par_bit}) push_req  = 1'b1;
      else                        par_err_c = 1'b1;
    end
  end

  // Shift register, bit index and inactivity counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shreg   <= 8'h00;
      idx     <= 3'd0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (state == S_IDLE || strobe) tcnt <= '0;
      else if (tcnt != {TW{1'b1}})   tcnt <= tcnt + TW'(1);

      if (strobe && !timeout) begin
        case (state)
          S_IDLE: idx <= 3'd0;
          S_DATA: begin
            shreg[idx] <= dat_s;
            idx        <= idx + 3'd1;
          end
          S_PAR:  par_bit <= dat_s;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = o_data_valid & i_data_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wptr] <= shreg;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count        <= count + CW'(do_push) - CW'(pop);
      o_parity_err <= par_err_c;
      o_frame_err  <= frm_err_c;
      o_overflow   <= push_req & ~do_push;
    end
  end

  assign o_data       = mem[rptr];
  assign o_data_valid = (count != '0);
  assign o_fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a table of single frames checked in a loop,
// plus hand-written sequences for overflow, full push+pop, timeout, glitch and
// mid-frame reset.
module tb_ps2_rx_fifo;
  localparam int SYNC  = 2;
  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 8;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = SYNC + 1 + FL;
  localparam int GLITCH_FRM = 0;
`else
  localparam int LAT = SYNC + 1;
  localparam int GLITCH_FRM = 1;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1, rdy = 1'b0;
  logic [7:0] data;
  logic       valid, perr, ferr, ovf;
  logic [3:0] cnt;

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO),
                .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_data(data), .o_data_valid(valid), .i_data_ready(rdy),
    .o_parity_err(perr), .o_frame_err(ferr), .o_overflow(ovf),
    .o_fifo_count(cnt));

  always #5 clk = ~clk;

  // Monitor: pulse counts and popped bytes (reads pre-edge values)
  int         n_par = 0, n_frm = 0, n_ovf = 0, n_vld = 0;
  logic [7:0] popq[$];
  always @(posedge clk) begin
    n_par += int'(perr);
    n_frm += int'(ferr);
    n_ovf += int'(ovf);
    n_vld += int'(valid);
    if (valid && rdy) popq.push_back(data);
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // pop_at_stop pulses ready exactly in the cycle the stop-bit push lands
  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input bit pop_at_stop);
    logic [9:0] bits;
    bits = {p, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    if (pop_at_stop) begin
      ps2_data = s;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (LAT) @(negedge clk);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      repeat (20 - LAT - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end else begin
      send_bit(s);
    end
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       p;
    logic       s;
    int         e_pop;
    int         e_par;
    int         e_frm;
  } vec_t;

  vec_t vecs[8];
  int   p0, f0, o0, v0, q0;

  initial begin
    // data, parity bit, stop bit, expected pops, parity errs, frame errs
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0};  // 3 ones, p=0 -> good
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0};  // bad parity
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1, 0, 0};
    vecs[6] = '{8'hA5, 1'b1, 1'b0, 0, 0, 1};  // stop bit 0
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 0, 1, 0};  // 6 ones, p=0 -> bad

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_pulses", int'({perr, ferr, ovf}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", int'(valid), 0);

    // Table-driven single frames, consumer always ready
    rdy = 1'b1;
    foreach (vecs[i]) begin
      p0 = n_par; f0 = n_frm; v0 = n_vld; q0 = popq.size();
      send_frame(vecs[i].b, vecs[i].p, vecs[i].s, 1'b0);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_pops", i), popq.size() - q0, vecs[i].e_pop);
      chk($sformatf("v%0d_vld_cycles", i), n_vld - v0, vecs[i].e_pop);
      chk($sformatf("v%0d_par", i), n_par - p0, vecs[i].e_par);
      chk($sformatf("v%0d_frm", i), n_frm - f0, vecs[i].e_frm);
      chk($sformatf("v%0d_count", i), int'(cnt), 0);
      if (vecs[i].e_pop == 1 && popq.size() > q0)
        chk($sformatf("v%0d_data", i), int'(popq[popq.size()-1]), int'(vecs[i].b));
    end

    // Overflow: 9 frames with consumer stalled
    rdy = 1'b0;
    o0 = n_ovf;
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] b;
      b = 8'(k);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("ovf_count", int'(cnt), 8);
    chk("ovf_pulses", n_ovf - o0, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("ovf_head%0d", k), int'(data), k);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
    end
    chk("ovf_drained", int'(cnt), 0);

    // Full FIFO with a pop in the same cycle as the 9th push
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = 8'h11 + 8'(k);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    chk("full_count", int'(cnt), 8);
    o0 = n_ovf; q0 = popq.size();
    send_frame(8'h19, 1'b0, 1'b1, 1'b1);  // 0x19: 3 ones -> p=0
    repeat (3) @(negedge clk);
    chk("pp_ovf", n_ovf - o0, 0);
    chk("pp_count", int'(cnt), 8);
    chk("pp_popped", popq.size() - q0, 1);
    if (popq.size() > q0) chk("pp_popped_data", int'(popq[q0]), 8'h11);
    q0 = popq.size();
    rdy = 1'b1;
    repeat (12) @(negedge clk);
    chk("pp_drain_n", popq.size() - q0, 8);
    if (popq.size() >= q0 + 8) begin
      chk("pp_first", int'(popq[q0]), 8'h12);
      chk("pp_last", int'(popq[q0+7]), 8'h19);
    end

    // Timeout mid-frame, then a clean frame
    f0 = n_frm;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    chk("to_frm", n_frm - f0, 1);
    f0 = n_frm; q0 = popq.size();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("to_next_frm", n_frm - f0, 0);
    chk("to_next_pops", popq.size() - q0, 1);
    if (popq.size() > q0) chk("to_next_data", int'(popq[q0]), 8'hF0);

    // Short low glitch on the PS/2 clock with data low while idle
    f0 = n_frm; p0 = n_par; q0 = popq.size();
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (TO + 20) @(negedge clk);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch_frm", n_frm - f0, GLITCH_FRM);
    chk("glitch_par", n_par - p0, 0);
    chk("glitch_pops", popq.size() - q0, 0);

    // Reset mid-frame with a byte stored
    rdy = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    chk("mr_count_before", int'(cnt), 1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_count", int'(cnt), 0);
    chk("mr_valid", int'(valid), 0);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rdy = 1'b1;
    f0 = n_frm; p0 = n_par; q0 = popq.size();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("mr_next_pops", popq.size() - q0, 1);
    if (popq.size() > q0) chk("mr_next_data", int'(popq[q0]), 8'h5A);
    chk("mr_next_errs", (n_frm - f0) + (n_par - p0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
